// File: rtl/nbit_rot_add_sub_if.sv
// nbit_rot_add_sub_if
//   Bus between the rotary front end and the add/sub block.
//   Inputs to the block : rot_event, rot_dir, slide[DIGIT_W], op
//   Outputs of the block: sum[WIDTH], carry, valid, state[2]
//   master = stimulus / decoder side, slave = nbit_rot_add_sub.
interface nbit_rot_add_sub_if #(
    parameter int WIDTH   = 7,
    parameter int DIGIT_W = 4
);
    logic               rot_event;
    logic               rot_dir;
    logic [DIGIT_W-1:0] slide;
    logic               op;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic               valid;
    logic [1:0]         state;

    modport master (
        output rot_event, rot_dir, slide, op,
        input  sum, carry, valid, state
    );

    modport slave (
        input  rot_event, rot_dir, slide, op,
        output sum, carry, valid, state
    );
endinterface

// File: rtl/nbit_rot_add_sub.sv
// nbit_rot_add_sub
//   Rotary operand entry and WIDTH-bit add/subtract.
//   Operands A and B are built digit by digit from the slide switches on
//   clockwise steps; counter-clockwise steps advance ENTER_A -> ENTER_B ->
//   RESULT -> back. Subtract reports no-borrow on carry.
// Ports
//   clk   : system clock, rising edge
//   rst_n : synchronous reset, active low
//   bus   : nbit_rot_add_sub_if.slave
//           rot_event/rot_dir/slide/op in; sum/carry/valid/state out
// Configuration
//   ACCUM_EN : when defined, CCW in RESULT loads the result into A and
//              continues in ENTER_B (running accumulator); otherwise both
//              operands are cleared and entry restarts in ENTER_A.
module nbit_rot_add_sub #(
    parameter int WIDTH   = 7,
    parameter int DIGIT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nbit_rot_add_sub_if.slave      bus
);

    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        RESULT  = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

    state_t           st;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             valid_r;
    logic             rot_q;

    logic             step;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   res;

    // Shift a digit into the LSBs; bits pushed past WIDTH are dropped.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] x,
                                                   input logic [DIGIT_W-1:0] d);
        return WIDTH'({x, d});
    endfunction

    always_comb begin
        step    = bus.rot_event & ~rot_q;
        a_shift = shift_in(a, bus.slide);
        b_shift = shift_in(b, bus.slide);
        // Subtract as A + ~B + 1 so the top bit is the no-borrow flag.
        b_eff   = bus.op ? ~b : b;
        res     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.op};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st      <= ENTER_A;
            a       <= '0;
            b       <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            valid_r <= 1'b0;
            rot_q   <= 1'b0;
        end else begin
            rot_q <= bus.rot_event;
            case (st)
                ENTER_A: begin
                    if (step) begin
                        if (bus.rot_dir) begin
                            a     <= a_shift;
                            sum_r <= a_shift;
                        end else begin
                            b     <= '0;
                            sum_r <= '0;
                            st    <= ENTER_B;
                        end
                    end
                end
                ENTER_B: begin
                    if (step) begin
                        if (bus.rot_dir) begin
                            b     <= b_shift;
                            sum_r <= b_shift;
                        end else begin
                            sum_r   <= res[WIDTH-1:0];
                            carry_r <= res[WIDTH];
                            valid_r <= 1'b1;
                            st      <= RESULT;
                        end
                    end
                end
                RESULT: begin
                    if (step && !bus.rot_dir) begin
`ifdef ACCUM_EN
                        a <= sum_r;
                        b <= '0;
                        st <= ENTER_B;
`else
                        a <= '0;
                        b <= '0;
                        st <= ENTER_A;
`endif
                        sum_r   <= '0;
                        carry_r <= 1'b0;
                        valid_r <= 1'b0;
                    end
                end
                default: begin
                    st      <= ENTER_A;
                    a       <= '0;
                    b       <= '0;
                    sum_r   <= '0;
                    carry_r <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sum   = sum_r;
    assign bus.carry = carry_r;
    assign bus.valid = valid_r;
    assign bus.state = st;

endmodule

// File: tb/tb_nbit_rot_add_sub.sv
// tb_nbit_rot_add_sub
//   Directed bench: a 7-bit/4-digit instance and a 12-bit/4-digit instance
//   fed the same rotary stimulus. Table of operand/result vectors plus
//   hand-written sequences for reset, held rot_event and RESULT handling.
module tb_nbit_rot_add_sub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    nbit_rot_add_sub_if #(.WIDTH(7),  .DIGIT_W(4)) b7 ();
    nbit_rot_add_sub_if #(.WIDTH(12), .DIGIT_W(4)) b12 ();

    assign b12.rot_event = b7.rot_event;
    assign b12.rot_dir   = b7.rot_dir;
    assign b12.slide     = b7.slide;
    assign b12.op        = b7.op;

    nbit_rot_add_sub #(.WIDTH(7), .DIGIT_W(4)) dut7 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b7)
    );

    nbit_rot_add_sub #(.WIDTH(12), .DIGIT_W(4)) dut12 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b12)
    );

    typedef struct {
        logic [3:0] a_hi;
        logic [3:0] a_lo;
        logic [3:0] b;
        logic       op;
        logic [6:0] exp_sum;
        logic       exp_carry;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One rotary step: rot_event high for one edge, then low for one edge so
    // the next step sees a fresh rising edge. Returns at a negedge.
    task automatic step(input logic dir, input logic [3:0] d, input logic o);
        b7.rot_dir   = dir;
        b7.slide     = d;
        b7.op        = o;
        b7.rot_event = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b7.rot_event = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        b7.rot_event = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{4'h5, 4'hA, 4'h3, 1'b0, 7'h5D, 1'b0};
        vecs[1] = '{4'hF, 4'hF, 4'h1, 1'b0, 7'h00, 1'b1};
        vecs[2] = '{4'h0, 4'h3, 4'h5, 1'b1, 7'h7E, 1'b0};
        vecs[3] = '{4'h0, 4'h5, 4'h3, 1'b1, 7'h02, 1'b1};
        vecs[4] = '{4'h0, 4'h0, 4'h0, 1'b1, 7'h00, 1'b1};
        vecs[5] = '{4'h7, 4'hF, 4'hF, 1'b1, 7'h70, 1'b1};
        vecs[6] = '{4'h2, 4'h0, 4'hF, 1'b0, 7'h2F, 1'b0};

        b7.rot_event = 1'b0;
        b7.rot_dir   = 1'b0;
        b7.slide     = '0;
        b7.op        = 1'b0;

        // Reset held for two cycles with rot_event pulsing.
        rst_n = 1'b0;
        @(negedge clk); b7.rot_event = 1'b1; b7.rot_dir = 1'b1; b7.slide = 4'h9;
        @(negedge clk); b7.rot_event = 1'b0;
        @(negedge clk); b7.rot_event = 1'b1;
        @(negedge clk);
        check("reset_state", {30'd0, b7.state}, 32'h0);
        check("reset_sum",   {25'd0, b7.sum}, 32'h0);
        check("reset_carry", {31'd0, b7.carry}, 32'h0);
        check("reset_valid", {31'd0, b7.valid}, 32'h0);
        check("reset_sum12", {20'd0, b12.sum}, 32'h0);
        b7.rot_event = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven operand/result vectors, reset between each.
        for (int unsigned i = 0; i < 7; i++) begin
            do_reset();
            step(1'b1, vecs[i].a_hi, 1'b0);
            step(1'b1, vecs[i].a_lo, 1'b0);
            check($sformatf("v%0d_mirror_a", i), {25'd0, b7.sum},
                  {25'd0, vecs[i].a_hi[2:0], vecs[i].a_lo});
            check($sformatf("v%0d_state_a", i), {30'd0, b7.state}, 32'h0);
            step(1'b0, 4'h0, 1'b0);
            check($sformatf("v%0d_state_b", i), {30'd0, b7.state}, 32'h1);
            step(1'b1, vecs[i].b, 1'b0);
            check($sformatf("v%0d_mirror_b", i), {25'd0, b7.sum}, {28'd0, vecs[i].b});
            step(1'b0, 4'h0, vecs[i].op);
            check($sformatf("v%0d_sum", i),   {25'd0, b7.sum}, {25'd0, vecs[i].exp_sum});
            check($sformatf("v%0d_carry", i), {31'd0, b7.carry}, {31'd0, vecs[i].exp_carry});
            check($sformatf("v%0d_valid", i), {31'd0, b7.valid}, 32'h1);
            check($sformatf("v%0d_state_r", i), {30'd0, b7.state}, 32'h2);
        end

        // 12-bit instance: A=0xFFF, B=1, add wraps to 0 with carry.
        do_reset();
        step(1'b1, 4'hF, 1'b0);
        step(1'b1, 4'hF, 1'b0);
        step(1'b1, 4'hF, 1'b0);
        check("w12_mirror_a", {20'd0, b12.sum}, 32'hFFF);
        check("w7_trunc_a",   {25'd0, b7.sum}, 32'h7F);
        step(1'b0, 4'h0, 1'b0);
        step(1'b1, 4'h1, 1'b0);
        step(1'b0, 4'h0, 1'b0);
        check("w12_sum",   {20'd0, b12.sum}, 32'h000);
        check("w12_carry", {31'd0, b12.carry}, 32'h1);

        // Held-high rot_event: one step only; sum updated the cycle after.
        do_reset();
        b7.rot_dir = 1'b1;
        b7.slide   = 4'h1;
        b7.rot_event = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("latency_sum", {25'd0, b7.sum}, 32'h1);
        for (int unsigned k = 0; k < 9; k++) begin
            @(posedge clk);
        end
        @(negedge clk);
        check("held_one_step", {25'd0, b7.sum}, 32'h1);
        b7.rot_event = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset wins over a same-cycle step mid-entry.
        b7.rot_dir = 1'b1;
        b7.slide   = 4'h9;
        b7.rot_event = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_sum",   {25'd0, b7.sum}, 32'h0);
        check("rst_mid_state", {30'd0, b7.state}, 32'h0);
        b7.rot_event = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Result hold: op changes and CW steps do not disturb it; then CCW.
        do_reset();
        step(1'b1, 4'h5, 1'b0);
        step(1'b1, 4'hA, 1'b0);
        step(1'b0, 4'h0, 1'b0);
        step(1'b1, 4'h3, 1'b0);
        step(1'b0, 4'h0, 1'b0);
        check("hold_sum0", {25'd0, b7.sum}, 32'h5D);
        b7.op = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hold_op_sum",   {25'd0, b7.sum}, 32'h5D);
        check("hold_op_carry", {31'd0, b7.carry}, 32'h0);
        step(1'b1, 4'h7, 1'b1);
        check("cw_result_sum",   {25'd0, b7.sum}, 32'h5D);
        check("cw_result_state", {30'd0, b7.state}, 32'h2);
        step(1'b0, 4'h0, 1'b0);
`ifdef ACCUM_EN
        check("accum_state", {30'd0, b7.state}, 32'h1);
        check("accum_sum",   {25'd0, b7.sum}, 32'h0);
        check("accum_valid", {31'd0, b7.valid}, 32'h0);
        step(1'b1, 4'h2, 1'b0);
        step(1'b0, 4'h0, 1'b1);
        check("accum_res_sum",   {25'd0, b7.sum}, 32'h5B);
        check("accum_res_carry", {31'd0, b7.carry}, 32'h1);
`else
        check("back_state", {30'd0, b7.state}, 32'h0);
        check("back_sum",   {25'd0, b7.sum}, 32'h0);
        check("back_valid", {31'd0, b7.valid}, 32'h0);
        check("back_carry", {31'd0, b7.carry}, 32'h0);
        // A was cleared: entering 2 shows 0x02, not 0x5D shifted.
        step(1'b1, 4'h2, 1'b0);
        check("back_cleared_a", {25'd0, b7.sum}, 32'h02);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
